timer_control_fsm: RTL and testbench

- Upstream control stage for the minutes/seconds countdown-countup counter.
- Conditions the raw board push-buttons: synchronise, debounce, edge-detect.
- Runs the timer mode state machine and drives the counter's enable, forward, incrementSeconds, incrementMinutes and clear inputs.
- Consumes the counter's finish flag to raise an alarm/blink indication for the VGA monitor.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/button_conditioner.sv | 69 ++++++
 rtl/timer_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_timer_control_fsm.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer control stage.
//   - state_t: mode state machine encoding, exposed on state_dbg.
//   - *_DEF:   default cycle counts at a 100 MHz system clock.
//   - cnt_width(): bits needed to hold 0..max_val inclusive.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  // 10 ms of stable level before a button change is believed.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  // One full 1 Hz period, so the slow counter samples exactly one edge.
  localparam int unsigned PULSE_CYCLES_DEF    = 100_000_000;
  // Half-period of the DONE blink.
  localparam int unsigned BLINK_CYCLES_DEF    = 50_000_000;

  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw push-button into a single-cycle press pulse.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_btn    raw, asynchronous, active-high button level
//   o_press  one-cycle pulse on an accepted 0->1 transition
// The new level is accepted only after DEBOUNCE_CYCLES consecutive samples
// that differ from the currently accepted level; any return to the accepted
// level restarts the count. Releases are tracked but never pulse.
module button_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_init;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The synchroniser is deliberately not reset: it keeps tracking the pin
  // through reset so the accepted level can be seeded from it afterwards.
  always_ff @(posedge i_clk) begin
    r_sync1 <= i_btn;
    r_sync2 <= r_sync1;
  end

  assign w_accept = (r_sync2 != r_stable) && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else if (!r_init) begin
      // First cycle out of reset: adopt the present level as history so a
      // button held through reset does not look like a fresh press.
      r_init   <= 1'b1;
      r_stable <= r_sync2;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_accept && r_sync2;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/timer_control_fsm.sv
// Control stage for the minutes/seconds counter: conditions the five board
// buttons, runs the IDLE/RUN/PAUSE/DONE/CLEAR mode machine and drives the
// counter controls plus the DONE alarm/blink indication.
//   clk, reset          100 MHz clock, async active-low reset
//   btn_*               raw buttons (start, mode, sec, min, clear)
//   finish              counter terminal flag, 1 Hz domain
//   enable, forward     counter run enable / direction (1 = up)
//   incrementSeconds,
//   incrementMinutes,
//   counter_clear       strobes held PULSE_CYCLES cycles
//   alarm, blink        DONE indication (blink half-period BLINK_CYCLES)
//   state_dbg           current state encoding
// Every output is a flop loaded from the next-state logic, so a decision made
// on an internal pulse appears on the outputs one clock later.
module timer_control_fsm
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int unsigned BLINK_CYCLES    = BLINK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_clear,
  input  logic       finish,
  output logic       enable,
  output logic       forward,
  output logic       incrementSeconds,
  output logic       incrementMinutes,
  output logic       counter_clear,
  output logic       alarm,
  output logic       blink,
  output logic [2:0] state_dbg
);

  localparam int unsigned MAX_CYC =
    (PULSE_CYCLES > BLINK_CYCLES) ? PULSE_CYCLES : BLINK_CYCLES;
  localparam int            CW     = cnt_width(MAX_CYC);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] B_LAST = CW'(BLINK_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic w_start_p, w_mode_p, w_sec_p, w_min_p, w_clear_p, w_fin_p;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_start), .o_press(w_start_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_mode), .o_press(w_mode_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sec (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_sec), .o_press(w_sec_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_min (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_min), .o_press(w_min_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .i_clk(clk), .i_rst_n(reset), .i_btn(btn_clear), .o_press(w_clear_p));

  // finish comes from the slow counter domain; only its rising edge matters.
  logic r_fin_s1, r_fin_s2, r_fin_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fin_s1   <= 1'b0;
      r_fin_s2   <= 1'b0;
      r_fin_prev <= 1'b0;
    end else begin
      r_fin_s1   <= finish;
      r_fin_s2   <= r_fin_s1;
      r_fin_prev <= r_fin_s2;
    end
  end

  assign w_fin_p = r_fin_s2 && !r_fin_prev;

  state_t        r_state, w_state_nxt;
  logic          r_enable, r_forward, w_forward_nxt;
  logic          r_alarm, r_cc;
  logic          r_blink, w_blink_nxt;
  logic          r_sec_on, w_sec_on_nxt;
  logic          r_min_on, w_min_on_nxt;
  logic [CW-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [CW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic [CW-1:0] r_sec_cnt, w_sec_cnt_nxt;
  logic [CW-1:0] r_min_cnt, w_min_cnt_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_forward_nxt   = r_forward;
    w_clr_cnt_nxt   = '0;
    w_blink_nxt     = 1'b0;
    w_blink_cnt_nxt = '0;
    w_sec_on_nxt    = r_sec_on;
    w_sec_cnt_nxt   = r_sec_cnt;
    w_min_on_nxt    = r_min_on;
    w_min_cnt_nxt   = r_min_cnt;

    // Priority inside each state: clear beats start, finish beats start.
    case (r_state)
      IDLE: begin
        if (w_mode_p) w_forward_nxt = ~r_forward;
        if (w_clear_p)      w_state_nxt = CLEAR;
        else if (w_start_p) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_fin_p)        w_state_nxt = DONE;
        else if (w_start_p) w_state_nxt = PAUSE;
      end
      PAUSE: begin
        if (w_clear_p)      w_state_nxt = CLEAR;
        else if (w_start_p) w_state_nxt = RUN;
      end
      DONE: begin
        if (w_start_p || w_clear_p) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        if (r_clr_cnt >= P_LAST) w_state_nxt = IDLE;
        else                     w_clr_cnt_nxt = r_clr_cnt + C_ONE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Clear strobe counts held cycles starting at 1 on entry.
    if (w_state_nxt == CLEAR && r_state != CLEAR) w_clr_cnt_nxt = C_ONE;

    // Blink starts high on DONE entry and flips every BLINK_CYCLES.
    if (w_state_nxt == DONE) begin
      if (r_state != DONE) begin
        w_blink_nxt     = 1'b1;
        w_blink_cnt_nxt = C_ONE;
      end else if (r_blink_cnt >= B_LAST) begin
        w_blink_nxt     = ~r_blink;
        w_blink_cnt_nxt = C_ONE;
      end else begin
        w_blink_nxt     = r_blink;
        w_blink_cnt_nxt = r_blink_cnt + C_ONE;
      end
    end

    // Increment stretches: armed only from IDLE, presses during an active
    // stretch are dropped, and a running stretch always finishes.
    if (r_sec_on) begin
      if (r_sec_cnt >= P_LAST) begin
        w_sec_on_nxt  = 1'b0;
        w_sec_cnt_nxt = '0;
      end else begin
        w_sec_cnt_nxt = r_sec_cnt + C_ONE;
      end
    end else if (r_state == IDLE && w_sec_p) begin
      w_sec_on_nxt  = 1'b1;
      w_sec_cnt_nxt = C_ONE;
    end

    if (r_min_on) begin
      if (r_min_cnt >= P_LAST) begin
        w_min_on_nxt  = 1'b0;
        w_min_cnt_nxt = '0;
      end else begin
        w_min_cnt_nxt = r_min_cnt + C_ONE;
      end
    end else if (r_state == IDLE && w_min_p) begin
      w_min_on_nxt  = 1'b1;
      w_min_cnt_nxt = C_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_enable    <= 1'b0;
      r_forward   <= 1'b1;
      r_alarm     <= 1'b0;
      r_cc        <= 1'b0;
      r_blink     <= 1'b0;
      r_sec_on    <= 1'b0;
      r_min_on    <= 1'b0;
      r_clr_cnt   <= '0;
      r_blink_cnt <= '0;
      r_sec_cnt   <= '0;
      r_min_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_enable    <= (w_state_nxt == RUN);
      r_forward   <= w_forward_nxt;
      r_alarm     <= (w_state_nxt == DONE);
      r_cc        <= (w_state_nxt == CLEAR);
      r_blink     <= w_blink_nxt;
      r_sec_on    <= w_sec_on_nxt;
      r_min_on    <= w_min_on_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_sec_cnt   <= w_sec_cnt_nxt;
      r_min_cnt   <= w_min_cnt_nxt;
    end
  end

  assign enable           = r_enable;
  assign forward          = r_forward;
  assign incrementSeconds = r_sec_on;
  assign incrementMinutes = r_min_on;
  assign counter_clear    = r_cc;
  assign alarm            = r_alarm;
  assign blink            = r_blink;
  assign state_dbg        = r_state;

endmodule

// File: tb/tb_timer_control_fsm.sv
// Bench for timer_control_fsm with DEBOUNCE_CYCLES=4, PULSE_CYCLES=8,
// BLINK_CYCLES=5. Outputs are sampled on the falling clock edge.
module tb_timer_control_fsm;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_mode, btn_sec, btn_min, btn_clear, finish;
  logic       enable, forward, incrementSeconds, incrementMinutes;
  logic       counter_clear, alarm, blink;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  timer_control_fsm #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(8),
    .BLINK_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_sec(btn_sec),
    .btn_min(btn_min), .btn_clear(btn_clear), .finish(finish),
    .enable(enable), .forward(forward),
    .incrementSeconds(incrementSeconds), .incrementMinutes(incrementMinutes),
    .counter_clear(counter_clear), .alarm(alarm), .blink(blink),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Running totals of strobe rising edges and high cycles.
  int  sec_rise = 0, sec_hi = 0, min_rise = 0, min_hi = 0, cc_rise = 0;
  logic sec_prev = 1'b0, min_prev = 1'b0, cc_prev = 1'b0;

  always @(negedge clk) begin
    if (incrementSeconds) sec_hi++;
    if (incrementSeconds && !sec_prev) sec_rise++;
    if (incrementMinutes) min_hi++;
    if (incrementMinutes && !min_prev) min_rise++;
    if (counter_clear && !cc_prev) cc_rise++;
    sec_prev = incrementSeconds;
    min_prev = incrementMinutes;
    cc_prev  = counter_clear;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] btns;      // {start, mode, sec, min, clear}
    int         exp_state;
    int         exp_enable;
    int         exp_forward;
    int         exp_alarm;
    int         exp_sec;   // strobe rising edges expected during the row
    int         exp_min;
    int         exp_cc;
  } vec_t;

  vec_t vecs[16];

  // ---------------- driver tasks ----------------
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btn_start, btn_mode, btn_sec, btn_min, btn_clear} = b;
    repeat (12) @(negedge clk);
    {btn_start, btn_mode, btn_sec, btn_min, btn_clear} = 5'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_rows(input int first, input int last);
    int s0, m0, c0;
    for (int i = first; i <= last; i++) begin
      s0 = sec_rise; m0 = min_rise; c0 = cc_rise;
      press(vecs[i].btns);
      chk($sformatf("row%0d_state", i),   int'(state_dbg), vecs[i].exp_state);
      chk($sformatf("row%0d_enable", i),  int'(enable),    vecs[i].exp_enable);
      chk($sformatf("row%0d_forward", i), int'(forward),   vecs[i].exp_forward);
      chk($sformatf("row%0d_alarm", i),   int'(alarm),     vecs[i].exp_alarm);
      chk($sformatf("row%0d_sec", i),     sec_rise - s0,   vecs[i].exp_sec);
      chk($sformatf("row%0d_min", i),     min_rise - m0,   vecs[i].exp_min);
      chk($sformatf("row%0d_cc", i),      cc_rise - c0,    vecs[i].exp_cc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int s0, h0, n;
    bit found;

    //                btns     st en fw al  s  m  c
    vecs[0]  = '{5'b01000, 0, 0, 0, 0, 0, 0, 0}; // mode in IDLE toggles
    vecs[1]  = '{5'b10000, 1, 1, 0, 0, 0, 0, 0}; // start -> RUN
    vecs[2]  = '{5'b01000, 1, 1, 0, 0, 0, 0, 0}; // mode ignored
    vecs[3]  = '{5'b00100, 1, 1, 0, 0, 0, 0, 0}; // sec ignored
    vecs[4]  = '{5'b00001, 1, 1, 0, 0, 0, 0, 0}; // clear ignored
    vecs[5]  = '{5'b10000, 2, 0, 0, 0, 0, 0, 0}; // start -> PAUSE
    vecs[6]  = '{5'b00100, 2, 0, 0, 0, 0, 0, 0}; // sec ignored
    vecs[7]  = '{5'b00010, 2, 0, 0, 0, 0, 0, 0}; // min ignored
    vecs[8]  = '{5'b01000, 2, 0, 0, 0, 0, 0, 0}; // mode ignored
    vecs[9]  = '{5'b10000, 1, 1, 0, 0, 0, 0, 0}; // start -> RUN
    vecs[10] = '{5'b10001, 0, 0, 0, 0, 0, 0, 1}; // IDLE start+clear -> CLEAR
    vecs[11] = '{5'b10100, 1, 1, 0, 0, 1, 0, 0}; // IDLE start+sec
    vecs[12] = '{5'b10000, 2, 0, 0, 0, 0, 0, 0}; // -> PAUSE
    vecs[13] = '{5'b10001, 0, 0, 0, 0, 0, 0, 1}; // PAUSE start+clear
    vecs[14] = '{5'b00001, 0, 0, 0, 0, 0, 0, 1}; // IDLE clear
    vecs[15] = '{5'b00010, 0, 0, 0, 0, 0, 1, 0}; // IDLE min

    reset = 1'b0;
    {btn_start, btn_mode, btn_sec, btn_min, btn_clear} = 5'b0;
    finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state",   int'(state_dbg),        0);
    chk("rst_enable",  int'(enable),           0);
    chk("rst_forward", int'(forward),          1);
    chk("rst_incsec",  int'(incrementSeconds), 0);
    chk("rst_incmin",  int'(incrementMinutes), 0);
    chk("rst_cc",      int'(counter_clear),    0);
    chk("rst_alarm",   int'(alarm),            0);
    chk("rst_blink",   int'(blink),            0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Bounce: level changes every 2 cycles never reach the 4-cycle threshold.
    s0 = sec_rise; h0 = sec_hi;
    for (int i = 0; i < 10; i++) begin
      btn_sec = ~btn_sec;
      repeat (2) @(negedge clk);
    end
    btn_sec = 1'b1;
    repeat (3) @(negedge clk);
    chk("bounce_no_strobe", sec_rise - s0, 0);
    repeat (20) @(negedge clk);
    chk("bounce_rises", sec_rise - s0, 1);
    chk("bounce_len",   sec_hi - h0,   8);
    btn_sec = 1'b0;
    repeat (12) @(negedge clk);
    chk("release_no_strobe", sec_rise - s0, 1);

    // Second min press lands while the first stretch is still high.
    s0 = min_rise; h0 = min_hi;
    btn_min = 1'b1; repeat (4) @(negedge clk);
    btn_min = 1'b0; repeat (4) @(negedge clk);
    btn_min = 1'b1; repeat (30) @(negedge clk);
    btn_min = 1'b0; repeat (12) @(negedge clk);
    chk("min_rises", min_rise - s0, 1);
    chk("min_len",   min_hi - h0,   8);

    run_rows(0, 9);

    // Finish: two sync flops plus one register -> DONE on the third edge.
    finish = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fin_not_yet", int'(state_dbg), 1);
    @(negedge clk);
    chk("fin_state",  int'(state_dbg), 3);
    chk("fin_alarm",  int'(alarm),     1);
    chk("fin_enable", int'(enable),    0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("blink_%0d", i), int'(blink), ((i / 5) % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    finish = 1'b0;

    // Clear from DONE with start and clear together.
    btn_start = 1'b1; btn_clear = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (counter_clear) found = 1'b1;
    end
    chk("clr_seen", int'(found), 1);
    chk("clr_state", int'(state_dbg), 4);
    chk("clr_alarm", int'(alarm), 0);
    n = 0;
    while (counter_clear && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("clr_len",     n,                 8);
    chk("clr_to_idle", int'(state_dbg),   0);
    chk("clr_alarm2",  int'(alarm),       0);
    chk("clr_blink",   int'(blink),       0);
    chk("clr_forward", int'(forward),     0);
    btn_start = 1'b0; btn_clear = 1'b0;
    repeat (12) @(negedge clk);

    run_rows(10, 15);

    // Async reset during the fourth high cycle of incrementSeconds.
    btn_sec = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (incrementSeconds) found = 1'b1;
    end
    chk("mid_seen", int'(found), 1);
    repeat (3) @(negedge clk);
    chk("mid_still_high", int'(incrementSeconds), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_incsec",  int'(incrementSeconds), 0);
    chk("mid_state",   int'(state_dbg),        0);
    chk("mid_forward", int'(forward),          1);
    chk("mid_enable",  int'(enable),           0);
    @(negedge clk);
    reset = 1'b1;
    // Button held through reset must not register as a new press.
    s0 = sec_rise;
    repeat (20) @(negedge clk);
    chk("held_no_press", sec_rise - s0, 0);
    btn_sec = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
